// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with lock for one registered memory port; read responses return MEM_RD_LATENCY+1 cycles after accept, no rsp backpressure.
// Optional conflict counter output conflict_cnt_o when MEM_ARB_STATS_EN is defined.
package mem_port_arbiter_pkg;
    localparam int DATA_FIELD_WIDTH = 32;
    localparam int ADDR_FIELD_WIDTH = 16;
    localparam int BYTE             = 8;
    localparam int WE_W             = DATA_FIELD_WIDTH / BYTE;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0]                   req_write_i,
    input  logic [NUM_REQ-1:0]                   req_lock_i,
    input  logic [NUM_REQ*WE_W-1:0]              req_we_i,
    input  logic [NUM_REQ*ADDR_FIELD_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ*DATA_FIELD_WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic [DATA_FIELD_WIDTH-1:0]          rsp_data_o,
    output logic                                 write_o,
    output logic [WE_W-1:0]                      we_o,
    output logic [ADDR_FIELD_WIDTH-1:0]          addr_o,
    output logic [DATA_FIELD_WIDTH-1:0]          data_o,
    input  logic [DATA_FIELD_WIDTH-1:0]          q_i
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]                          conflict_cnt_o
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W:0]         cand;
    logic                   accept;
    logic [NUM_REQ-1:0]     grant;

    logic                         write_q;
    logic [WE_W-1:0]              we_q;
    logic [ADDR_FIELD_WIDTH-1:0]  addr_q;
    logic [DATA_FIELD_WIDTH-1:0]  data_q;
    logic                         rd_vld_q;
    logic [IDX_W-1:0]             rd_idx_q;
    logic [MEM_RD_LATENCY-1:0]    tag_vld_q;
    logic [IDX_W-1:0]             tag_idx_q [MEM_RD_LATENCY];

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        accept    = 1'b0;
        cand      = '0;
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        if (!reset_i) begin
            if (state_q == LOCKED) begin
                if (req_valid_i[owner_q]) begin
                    accept    = 1'b1;
                    grant_idx = owner_q;
                end
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
                    if (cand >= (IDX_W+1)'(NUM_REQ))
                        cand = cand - (IDX_W+1)'(NUM_REQ);
                    if (!accept && req_valid_i[cand[IDX_W-1:0]]) begin
                        accept    = 1'b1;
                        grant_idx = cand[IDX_W-1:0];
                    end
                end
            end
        end
        if (accept) begin
            grant = NUM_REQ'(1) << grant_idx;
            if (state_q == IDLE) begin
                ptr_d = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
                if (req_lock_i[grant_idx]) begin
                    state_d = LOCKED;
                    owner_d = grant_idx;
                end
            end else if (!req_lock_i[grant_idx]) begin
                state_d = IDLE;
            end
        end
    end

    assign req_ready_o = grant;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Memory port stage; the read tag rides alongside the address it belongs to.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            write_q  <= 1'b0;
            we_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            write_q  <= accept & req_write_i[grant_idx];
            we_q     <= (accept && req_write_i[grant_idx]) ?
                        req_we_i[grant_idx*WE_W +: WE_W] : '0;
            if (accept) begin
                addr_q <= req_addr_i[grant_idx*ADDR_FIELD_WIDTH +: ADDR_FIELD_WIDTH];
                data_q <= req_data_i[grant_idx*DATA_FIELD_WIDTH +: DATA_FIELD_WIDTH];
            end
            rd_vld_q <= accept & ~req_write_i[grant_idx];
            rd_idx_q <= grant_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_vld_q <= '0;
            for (int k = 0; k < MEM_RD_LATENCY; k++) tag_idx_q[k] <= '0;
        end else begin
            tag_vld_q[0] <= rd_vld_q;
            tag_idx_q[0] <= rd_idx_q;
            for (int k = 1; k < MEM_RD_LATENCY; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (tag_vld_q[MEM_RD_LATENCY-1])
            rsp_valid_o = NUM_REQ'(1) << tag_idx_q[MEM_RD_LATENCY-1];
    end

    assign rsp_data_o = q_i;
    assign write_o    = write_q;
    assign we_o       = we_q;
    assign addr_o     = addr_q;
    assign data_o     = data_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            conflict_cnt_q <= '0;
        else if (($countones(req_valid_i) >= 2) && (conflict_cnt_q != '1))
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NUM_REQ=4, MEM_RD_LATENCY=1).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = ADDR_FIELD_WIDTH;
    localparam int DW = DATA_FIELD_WIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_ready, req_write, req_lock, rsp_valid;
    logic [N*WE_W-1:0] req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [DW-1:0]     rsp_data, data, q;
    logic              write;
    logic [WE_W-1:0]   we;
    logic [AW-1:0]     addr;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]       conflict_cnt;
`endif

    int errs   = 0;
    int checks = 0;

    mem_port_arbiter #(.NUM_REQ(N), .MEM_RD_LATENCY(1)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_lock_i  (req_lock),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .write_o     (write),
        .we_o        (we),
        .addr_o      (addr),
        .data_o      (data),
        .q_i         (q)
`ifdef MEM_ARB_STATS_EN
        ,
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle memory: address seen in one cycle, data tagged with it the next.
    always @(posedge clk) q <= {16'hA5A5, addr};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i, input logic v, input logic wr, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]            = v;
        req_write[i]            = wr;
        req_lock[i]             = lk;
        req_addr[i*AW +: AW]    = a;
        req_data[i*DW +: DW]    = d;
        req_we[i*WE_W +: WE_W]  = '1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] exp_rdy, exp_rsp;
        reset = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 1'b0, AW'(16'h10 + i), DW'(i));

        // Reset held two cycles with all requesters valid
        for (int c = 0; c < 2; c++) begin
            nxt(); #1;
            check("rst_ready", req_ready, 4'b0000);
            check("rst_write", write, 1'b0);
            check("rst_we", we, 4'h0);
            check("rst_addr", addr, 16'h0);
            check("rst_rsp", rsp_valid, 4'b0000);
        end

        // Round-robin reads, then two drain cycles
        for (int k = 0; k < 10; k++) begin
            nxt();
            if (k == 0) reset = 1'b0;
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_rdy = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
            check("rr_ready", req_ready, exp_rdy);
            if (k >= 1) begin
                check("rr_write", write, 1'b0);
                check("rr_we_read", we, 4'h0);
            end
            if (k >= 2) begin
                exp_rsp = 4'(1 << ((k - 2) % 4));
                check("rr_rsp", rsp_valid, exp_rsp);
                check("rr_rsp_data", rsp_data, {16'hA5A5, 16'(16'h10 + (k - 2) % 4)});
            end else begin
                check("rr_rsp_idle", rsp_valid, 4'b0000);
            end
        end

        // Write from requester 2
        idle_all();
        nxt();
        drive(2, 1'b1, 1'b1, 1'b0, 16'h0040, 32'hDEADBEEF);
        #1;
        check("wr_ready", req_ready, 4'b0100);
        nxt(); idle_all(); #1;
        check("wr_write", write, 1'b1);
        check("wr_we", we, 4'hF);
        check("wr_addr", addr, 16'h0040);
        check("wr_data", data, 32'hDEADBEEF);
        check("wr_rsp", rsp_valid, 4'b0000);
        nxt(); #1;
        check("wr_idle_write", write, 1'b0);
        check("wr_idle_we", we, 4'h0);
        check("wr_addr_hold", addr, 16'h0040);
        check("wr_no_rsp", rsp_valid, 4'b0000);

        // Lock: move ptr to 1, then requester 1 holds the port for two accesses
        nxt();
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0050, 32'h0);
        #1;
        check("lk_pre", req_ready, 4'b0001);
        nxt();
        drive(1, 1'b1, 1'b0, 1'b1, 16'h0021, 32'h0);
        drive(3, 1'b1, 1'b0, 1'b0, 16'h0053, 32'h0);
        #1;
        check("lk_first", req_ready, 4'b0010);
        nxt();
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0022, 32'h12345678);
        #1;
        check("lk_second", req_ready, 4'b0010);
        check("lk_rd_port", write, 1'b0);
        nxt();
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        check("lk_then3", req_ready, 4'b1000);
        check("lk_wr_port", write, 1'b1);
        check("lk_wr_addr", addr, 16'h0022);
        check("lk_wr_data", data, 32'h12345678);
        nxt(); #1;
        check("lk_then0", req_ready, 4'b0001);

        // Reset while a locked read from requester 1 is in flight
        nxt(); idle_all();
        drive(1, 1'b1, 1'b0, 1'b1, 16'h0061, 32'h0);
        #1;
        check("mr_accept", req_ready, 4'b0010);
        nxt();
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0070, 32'h0);
        #1;
        check("mr_rst_ready", req_ready, 4'b0000);
        nxt();
        reset = 1'b0;
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 1'b0, AW'(16'h70 + i), 32'h0);
        #1;
        check("mr_ptr0_idle", req_ready, 4'b0001);
        check("mr_rsp_dropped", rsp_valid, 4'b0000);
        check("mr_addr_clr", addr, 16'h0000);
        check("mr_write_clr", write, 1'b0);
        nxt(); idle_all(); #1;
        check("mr_rsp_quiet", rsp_valid, 4'b0000);
        nxt(); #1;
        check("mr_rsp_new", rsp_valid, 4'b0001);
        check("mr_rsp_new_data", rsp_data, 32'hA5A50070);

`ifdef MEM_ARB_STATS_EN
        nxt(); reset = 1'b1; #1;
        nxt(); reset = 1'b0; #1;
        check("st_cnt_rst", conflict_cnt, 32'd0);
        for (int c = 0; c < 8; c++) begin
            req_valid = (c < 5) ? 4'b0011 : 4'b0001;
            nxt();
        end
        idle_all();
        nxt(); #1;
        check("st_cnt", conflict_cnt, 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the memory port.
REQ-002 SHALL have parameter MEM_RD_LATENCY, default 1, cycles from memory addr driven to q valid (legal range 1-4).
REQ-003 SHALL take DATA_FIELD_WIDTH, ADDR_FIELD_WIDTH and BYTE from the package constants; WE_W = DATA_FIELD_WIDTH/BYTE.
REQ-004 SHALL have a single clock and a synchronous, active-high reset: clk input 1 is the clock, all state on rising edge; reset input 1 is the synchronous active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_ready  output  NUM_REQ  per-requester grant; accept = req_valid[i] & req_ready[i].
REQ-007 req_write  input  NUM_REQ  1 = write, 0 = read.
REQ-008 req_lock  input  NUM_REQ  hold port for the same requester after this access.
REQ-009 req_we  input  NUM_REQ*WE_W  byte enables, slice i.
REQ-010 req_addr  input  NUM_REQ*ADDR_FIELD_WIDTH  address, slice i.
REQ-011 req_data  input  NUM_REQ*DATA_FIELD_WIDTH  write data, slice i.
REQ-012 rsp_valid  output  NUM_REQ  one-hot read-response valid.
REQ-013 rsp_data  output  DATA_FIELD_WIDTH  read data, shared by all requesters.
REQ-014 write, we, addr, data  output  1 / WE_W / ADDR_FIELD_WIDTH / DATA_FIELD_WIDTH  memory port, registered.
REQ-015 q  input  DATA_FIELD_WIDTH  memory read data.

Function
REQ-016 SHALL accept at most one request per cycle; req_ready SHALL be combinational, at most one bit set, and only set where req_valid is set.
REQ-017 SHALL use round-robin: search starts at pointer ptr; after an accept from i, ptr <= (i+1) mod NUM_REQ; with no accept, ptr holds.
REQ-018 SHALL have states IDLE and LOCKED(owner); IDLE -> LOCKED(i) on accept from i with req_lock[i]=1; LOCKED(i) -> IDLE on accept from i with req_lock[i]=0.
REQ-019 SHALL, in LOCKED(i), assert req_ready only to i; other requesters SHALL wait regardless of ptr; ptr is not updated while LOCKED.
REQ-020 SHALL register the accepted request onto the memory port in the cycle after accept (T+1): write=req_write, we, addr, data from slice i.
REQ-021 SHALL, in the cycle after accept, present write=0 and we=0 when no accept occurred; addr/data hold their last value.
REQ-022 SHALL force we=0 on memory-port reads.
REQ-023 SHALL track each read in a MEM_RD_LATENCY-deep tag shift register (valid + requester index).
REQ-024 SHALL assert rsp_valid[i] in cycle T+1+MEM_RD_LATENCY for a read accepted from i at T, with rsp_data=q that cycle; writes produce no response.
REQ-025 SHALL sustain back-to-back accepts every cycle; responses SHALL return in accept order, with no backpressure on rsp.
REQ-026 SHALL, with all req_valid=0, keep req_ready=0 and state, ptr unchanged.
REQ-027 SHALL drive rsp_data = q even when rsp_valid=0; consumers qualify data with rsp_valid.

Reset
REQ-028 SHALL, on reset, set state=IDLE, ptr=0, write=0, we=0, addr=0, data=0, tag pipeline cleared (rsp_valid=0 from next cycle), req_ready=0 while reset is high.
REQ-029 SHALL drop in-flight reads at reset; no rsp_valid for requests accepted before reset asserted.
REQ-030 SHALL release a LOCKED owner on reset.

Configuration
REQ-031 SHALL, when macro MEM_ARB_STATS_EN is defined, add output conflict_cnt (32 bits), counting cycles with >=2 req_valid bits set, saturating at all ones, cleared by reset.
REQ-032 SHALL, when MEM_ARB_STATS_EN is undefined, omit conflict_cnt and all associated logic; all other behaviour identical.

Verification
REQ-033 Reset: reset=1 two cycles with req_valid=4'b1111 -> req_ready=0, write=0, we=0, rsp_valid=0; after release first grant goes to requester 0.
REQ-034 Round-robin: req_valid=4'b1111 held, all reads, 8 cycles -> grant order 0,1,2,3,0,1,2,3; rsp_valid one-hot in the same order, starting 2 cycles after first accept (MEM_RD_LATENCY=1).
REQ-035 Write path: requester 2 write addr=0x40, data=0xDEADBEEF, we=all ones at T -> at T+1 write=1, addr=0x40, data=0xDEADBEEF; no rsp_valid.
REQ-036 Lock: requester 1 read with req_lock=1, then write with req_lock=0, requesters 0,3 valid throughout -> 1 granted twice consecutively, then 3, then 0.
REQ-037 Reset mid-operation: reads from 0 and 1 in flight, reset for one cycle -> no rsp_valid for them; state IDLE; ptr=0.
REQ-038 Stats (MEM_ARB_STATS_EN): req_valid=4'b0011 for 5 cycles, then 4'b0001 for 3 -> conflict_cnt=5.
